// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect definitions: bus widths, slave count,
// response codes and the read-router state encoding.
package axil_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int NUMBER_SLAVE   = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ERR
    } state_type_rt;

endpackage

// File: rtl/axil_router_rd_if.sv
// Read-channel bundle of the router: one master-facing AR/R port and NUMBER_SLAVE
// slave-facing AR/R ports. Modport "slave" is the router's view, "master" the environment's.
interface axil_router_rd_if;
    import axil_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0]                    m_axil_araddr;
    logic [2:0]                                   m_axil_arprot;
    logic                                         m_axil_arvalid;
    logic                                         m_axil_arready;
    logic [AXI_DATA_WIDTH-1:0]                    m_axil_rdata;
    logic [1:0]                                   m_axil_rresp;
    logic                                         m_axil_rvalid;
    logic                                         m_axil_rready;

    logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0]  s_axil_araddr;
    logic [NUMBER_SLAVE-1:0][2:0]                 s_axil_arprot;
    logic [NUMBER_SLAVE-1:0]                      s_axil_arvalid;
    logic [NUMBER_SLAVE-1:0]                      s_axil_arready;
    logic [NUMBER_SLAVE-1:0][AXI_DATA_WIDTH-1:0]  s_axil_rdata;
    logic [NUMBER_SLAVE-1:0][1:0]                 s_axil_rresp;
    logic [NUMBER_SLAVE-1:0]                      s_axil_rvalid;
    logic [NUMBER_SLAVE-1:0]                      s_axil_rready;

    modport slave (
        input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready
    );

    modport master (
        output m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready
    );

endinterface

// File: rtl/axil_err_resp_rd.sv
// Internal default slave: accepts the AR beat with a one-cycle arready pulse,
// then presents a single error R beat (DECERR or SLVERR) with zero data.
module axil_err_resp_rd
    import axil_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      skip_addr,
    input  logic                      active,
    input  logic [1:0]                resp,
    input  logic                      rready,
    output logic                      arready,
    output logic                      rvalid,
    output logic [AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                rresp,
    output logic                      done
);

    logic addr_done;

    // skip_addr is used when the AR beat was already consumed by a real slave
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_done <= 1'b0;
        end else if (start) begin
            addr_done <= skip_addr;
        end else if (active && !addr_done) begin
            addr_done <= 1'b1;
        end else if (done) begin
            addr_done <= 1'b0;
        end
    end

    always_comb begin
        arready = active && !addr_done;
        rvalid  = active && addr_done;
        rdata   = '0;
        rresp   = rvalid ? resp : RESP_OKAY;
        done    = rvalid && rready;
    end

endmodule

// File: rtl/axil_router_rd.sv
// AXI-Lite read-channel router: one outstanding read, unmapped reads answered with DECERR.
// Optional AXIL_RD_TIMEOUT_EN adds a watchdog that abandons a stuck slave with SLVERR.
module axil_router_rd
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NUMBER_SLAVE:0] slv_valid,
    axil_router_rd_if.slave       bus
);

    state_type_rt              state, state_next;
    logic [NUMBER_SLAVE:0]     sel, sel_next, pick;
    logic                      ar_hs, r_hs, timeout;
    logic                      err_start, err_skip, err_arready, err_rvalid, err_done;
    logic [AXI_DATA_WIDTH-1:0] err_rdata;
    logic [1:0]                err_rresp, err_resp;

    // Lowest set bit wins when the address map overlaps
    assign pick  = slv_valid & (~slv_valid + (NUMBER_SLAVE+1)'(1));
    assign ar_hs = bus.m_axil_arvalid && |(sel[NUMBER_SLAVE-1:0] & bus.s_axil_arready);
    assign r_hs  = bus.m_axil_rready && |(sel[NUMBER_SLAVE-1:0] & bus.s_axil_rvalid);

    // A mapped select still held in ERR means the watchdog fired
    assign err_resp = sel[NUMBER_SLAVE] ? RESP_DECERR : RESP_SLVERR;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting = (state == ADDR && !ar_hs) || (state == DATA && !r_hs);
    assign timeout = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        err_start  = 1'b0;
        err_skip   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m_axil_arvalid && |slv_valid) begin
                    sel_next = pick;
                    if (pick[NUMBER_SLAVE]) begin
                        state_next = ERR;
                        err_start  = 1'b1;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_next = DATA;
                end else if (timeout) begin
                    state_next = ERR;
                    err_start  = 1'b1;
                end
            end
            DATA: begin
                if (r_hs) begin
                    state_next = IDLE;
                    sel_next   = '0;
                end else if (timeout) begin
                    state_next = ERR;
                    err_start  = 1'b1;
                    err_skip   = 1'b1;
                end
            end
            ERR: begin
                if (err_done) begin
                    state_next = IDLE;
                    sel_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
            end
        endcase
    end

    always_comb begin
        bus.m_axil_arready = 1'b0;
        bus.m_axil_rvalid  = 1'b0;
        bus.m_axil_rdata   = '0;
        bus.m_axil_rresp   = RESP_OKAY;
        bus.s_axil_arvalid = '0;
        bus.s_axil_rready  = '0;
        for (int k = 0; k < NUMBER_SLAVE; k++) begin
            bus.s_axil_araddr[k] = bus.m_axil_araddr;
            bus.s_axil_arprot[k] = bus.m_axil_arprot;
        end
        case (state)
            ADDR: begin
                bus.m_axil_arready = |(sel[NUMBER_SLAVE-1:0] & bus.s_axil_arready);
                for (int k = 0; k < NUMBER_SLAVE; k++) begin
                    bus.s_axil_arvalid[k] = sel[k] & bus.m_axil_arvalid;
                end
            end
            DATA: begin
                for (int k = 0; k < NUMBER_SLAVE; k++) begin
                    bus.m_axil_rvalid    = bus.m_axil_rvalid | (sel[k] & bus.s_axil_rvalid[k]);
                    bus.m_axil_rdata     = bus.m_axil_rdata | (bus.s_axil_rdata[k] & {AXI_DATA_WIDTH{sel[k]}});
                    bus.m_axil_rresp     = bus.m_axil_rresp | (bus.s_axil_rresp[k] & {2{sel[k]}});
                    bus.s_axil_rready[k] = sel[k] & bus.m_axil_rready;
                end
            end
            ERR: begin
                bus.m_axil_arready = err_arready;
                bus.m_axil_rvalid  = err_rvalid;
                bus.m_axil_rdata   = err_rdata;
                bus.m_axil_rresp   = err_rresp;
            end
            default: begin
            end
        endcase
    end

    axil_err_resp_rd u_err (
        .clk       (aclk),
        .rst       (areset),
        .start     (err_start),
        .skip_addr (err_skip),
        .active    (state == ERR),
        .resp      (err_resp),
        .rready    (bus.m_axil_rready),
        .arready   (err_arready),
        .rvalid    (err_rvalid),
        .rdata     (err_rdata),
        .rresp     (err_rresp),
        .done      (err_done)
    );

endmodule

// File: tb/tb_axil_router_rd.sv
// Self-checking bench for axil_router_rd: randomized slave/master timing checked against
// a transaction-level model of expected latency, data and response.
module tb_axil_router_rd;
    import axil_pkg::*;

    localparam int NS = NUMBER_SLAVE;
    localparam int TO = 8;

    typedef struct packed {
        int                        sav_cyc;
        int                        ar_cyc;
        int                        rv_cyc;
        int                        hs_cyc;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        int                        proto_err;
    } obs_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [NS:0]   slv_valid;
    int            n_checks = 0;
    int            n_fail = 0;

    axil_router_rd_if bus ();

    axil_router_rd #(.TIMEOUT_CYCLES(TO)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .slv_valid (slv_valid),
        .bus       (bus)
    );

    always #5 aclk = ~aclk;

    // Expected outcome of one read, counted in cycles from the master's first arvalid
    function automatic obs_t model(input logic [NS:0] tgt, input int ar_dly, input int r_dly,
                                   input int rr_hold, input logic [AXI_DATA_WIDTH-1:0] sdata,
                                   input logic [1:0] sresp);
        obs_t e;
        int   k;
        k = -1;
        for (int i = 0; i <= NS; i++) if (tgt[i] && k < 0) k = i;
        e.proto_err = 0;
        if (k == NS) begin
            e.sav_cyc = -1;
            e.ar_cyc  = 2;
            e.rv_cyc  = 3;
            e.data    = '0;
            e.resp    = RESP_DECERR;
        end else begin
            e.sav_cyc = 2;
            e.ar_cyc  = 2 + ar_dly;
            e.rv_cyc  = e.ar_cyc + 1 + r_dly;
            e.data    = sdata;
            e.resp    = sresp;
`ifdef AXIL_RD_TIMEOUT_EN
            if (r_dly < 0 || r_dly >= TO) begin
                e.rv_cyc = e.ar_cyc + 1 + TO;
                e.data   = '0;
                e.resp   = RESP_SLVERR;
            end
`endif
        end
        e.hs_cyc = e.rv_cyc + rr_hold;
        return e;
    endfunction

    // Plays master, decoder and all slaves for one read; unselected slaves drive random noise
    task automatic do_read(input logic [NS:0] tgt, input int ar_dly, input int r_dly,
                           input int rr_hold, input logic [AXI_DATA_WIDTH-1:0] sdata,
                           input logic [1:0] sresp, output obs_t o);
        int                        k;
        bit                        ar_done, done;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [2:0]                prot;
        logic [AXI_DATA_WIDTH-1:0] first_data;
        logic [1:0]                first_resp;
        k = NS;
        for (int i = NS; i >= 0; i--) if (tgt[i]) k = i;
        addr = $urandom;
        prot = 3'($urandom);
        o = '{sav_cyc: -1, ar_cyc: -1, rv_cyc: -1, hs_cyc: -1, data: '0, resp: '0, proto_err: 0};
        ar_done = 1'b0;
        done = 1'b0;
        first_data = '0;
        first_resp = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge aclk);
            bus.m_axil_arvalid = !ar_done;
            bus.m_axil_araddr  = addr;
            bus.m_axil_arprot  = prot;
            bus.m_axil_rready  = 1'b0;
            slv_valid = (c >= 1) ? tgt : '0;
            for (int i = 0; i < NS; i++) begin
                bus.s_axil_arready[i] = 1'($urandom_range(0, 1));
                bus.s_axil_rvalid[i]  = 1'($urandom_range(0, 1));
                bus.s_axil_rdata[i]   = $urandom;
                bus.s_axil_rresp[i]   = 2'($urandom);
            end
            if (k < NS) begin
                bus.s_axil_arready[k] = !ar_done && (c >= 2 + ar_dly);
                bus.s_axil_rvalid[k]  = ar_done && (r_dly >= 0) && (c >= o.ar_cyc + 1 + r_dly);
                bus.s_axil_rdata[k]   = bus.s_axil_rvalid[k] ? sdata : AXI_DATA_WIDTH'($urandom);
                bus.s_axil_rresp[k]   = bus.s_axil_rvalid[k] ? sresp : 2'($urandom);
            end
            #1;
            if (bus.m_axil_rvalid && o.rv_cyc < 0) begin
                o.rv_cyc   = c;
                first_data = bus.m_axil_rdata;
                first_resp = bus.m_axil_rresp;
            end
            bus.m_axil_rready = (o.rv_cyc >= 0) && (c >= o.rv_cyc + rr_hold);
            #1;
            if (c < 2 && (bus.m_axil_arready || bus.m_axil_rvalid || |bus.s_axil_arvalid || |bus.s_axil_rready))
                o.proto_err++;
            for (int i = 0; i < NS; i++) begin
                if (i != k && (bus.s_axil_arvalid[i] || bus.s_axil_rready[i])) o.proto_err++;
                if (bus.s_axil_araddr[i] !== addr || bus.s_axil_arprot[i] !== prot) o.proto_err++;
            end
            if (k < NS && bus.s_axil_arvalid[k] && o.sav_cyc < 0) o.sav_cyc = c;
            if (o.rv_cyc >= 0 && (!bus.m_axil_rvalid || bus.m_axil_rdata !== first_data || bus.m_axil_rresp !== first_resp))
                o.proto_err++;
            if (!ar_done && bus.m_axil_arvalid && bus.m_axil_arready) begin
                o.ar_cyc = c;
                ar_done  = 1'b1;
            end
            if (bus.m_axil_rvalid && bus.m_axil_rready) begin
                o.hs_cyc = c;
                o.data   = bus.m_axil_rdata;
                o.resp   = bus.m_axil_rresp;
                done     = 1'b1;
            end
        end
        if (!done) o.proto_err++;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        slv_valid = 3'b100;
        bus.m_axil_arvalid = 1'b1;
        bus.m_axil_araddr  = '0;
        bus.m_axil_arprot  = '0;
        bus.m_axil_rready  = 1'b1;
        bus.s_axil_arready = '1;
        bus.s_axil_rvalid  = '1;
        bus.s_axil_rdata   = '1;
        bus.s_axil_rresp   = '1;
        repeat (3) @(negedge aclk);
        #1;
        n_checks++;
        if ({bus.m_axil_arready, bus.m_axil_rvalid, bus.m_axil_rdata, bus.m_axil_rresp,
             bus.s_axil_arvalid, bus.s_axil_rready} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got arready=%b rvalid=%b rdata=%h rresp=%b s_arvalid=%b s_rready=%b, required all 0",
                     bus.m_axil_arready, bus.m_axil_rvalid, bus.m_axil_rdata, bus.m_axil_rresp,
                     bus.s_axil_arvalid, bus.s_axil_rready);
        end
        @(negedge aclk);
        slv_valid = '0;
        bus.m_axil_arvalid = 1'b0;
        bus.m_axil_rready  = 1'b0;
        bus.s_axil_arready = '0;
        bus.s_axil_rvalid  = '0;
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        n_checks++;
        if ({bus.m_axil_arready, bus.m_axil_rvalid, bus.s_axil_arvalid, bus.s_axil_rready} !== '0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got arready=%b rvalid=%b s_arvalid=%b s_rready=%b, required all 0",
                     bus.m_axil_arready, bus.m_axil_rvalid, bus.s_axil_arvalid, bus.s_axil_rready);
        end
    endtask

    task automatic test_mapped_read;
        obs_t o, e;
        e = model(3'b010, 3, 1, 0, 32'hCAFE_0001, RESP_OKAY);
        do_read(3'b010, 3, 1, 0, 32'hCAFE_0001, RESP_OKAY, o);
        n_checks++;
        if (o.data !== e.data || o.resp !== e.resp) begin
            n_fail++;
            $display("[TB] FAIL mapped_data: got %h/%b, required %h/%b", o.data, o.resp, e.data, e.resp);
        end
        n_checks++;
        if ({o.sav_cyc, o.ar_cyc, o.rv_cyc, o.hs_cyc} !== {e.sav_cyc, e.ar_cyc, e.rv_cyc, e.hs_cyc}) begin
            n_fail++;
            $display("[TB] FAIL mapped_timing: got sav/ar/rv/hs %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                     o.sav_cyc, o.ar_cyc, o.rv_cyc, o.hs_cyc, e.sav_cyc, e.ar_cyc, e.rv_cyc, e.hs_cyc);
        end
        n_checks++;
        if (o.proto_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL mapped_protocol: got %0d violations, required 0", o.proto_err);
        end
    endtask

    task automatic test_unmapped;
        obs_t o, e;
        e = model(3'b100, 0, 0, 0, '0, RESP_OKAY);
        do_read(3'b100, 0, 0, 0, '0, RESP_OKAY, o);
        n_checks++;
        if (o.data !== e.data || o.resp !== e.resp) begin
            n_fail++;
            $display("[TB] FAIL unmapped_decerr: got %h/%b, required %h/%b", o.data, o.resp, e.data, e.resp);
        end
        n_checks++;
        if ({o.sav_cyc, o.ar_cyc, o.rv_cyc, o.hs_cyc} !== {e.sav_cyc, e.ar_cyc, e.rv_cyc, e.hs_cyc}) begin
            n_fail++;
            $display("[TB] FAIL unmapped_timing: got sav/ar/rv/hs %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                     o.sav_cyc, o.ar_cyc, o.rv_cyc, o.hs_cyc, e.sav_cyc, e.ar_cyc, e.rv_cyc, e.hs_cyc);
        end
        n_checks++;
        if (o.proto_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL unmapped_protocol: got %0d violations, required 0", o.proto_err);
        end
    endtask

    task automatic test_rready_hold;
        obs_t                      o, e;
        logic [AXI_DATA_WIDTH-1:0] d;
        d = $urandom;
        e = model(3'b001, 1, 0, 5, d, RESP_SLVERR);
        do_read(3'b001, 1, 0, 5, d, RESP_SLVERR, o);
        n_checks++;
        if (o.data !== e.data || o.resp !== e.resp || o.hs_cyc !== e.hs_cyc) begin
            n_fail++;
            $display("[TB] FAIL hold_complete: got %h/%b at %0d, required %h/%b at %0d",
                     o.data, o.resp, o.hs_cyc, e.data, e.resp, e.hs_cyc);
        end
        n_checks++;
        if (o.proto_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL hold_stable: got %0d violations, required 0", o.proto_err);
        end
    endtask

    task automatic test_back_to_back;
        obs_t                      o, e;
        logic [NS:0]               tgt;
        logic [AXI_DATA_WIDTH-1:0] d;
        for (int n = 0; n < 2; n++) begin
            tgt = (n == 0) ? 3'b001 : 3'b010;
            d   = $urandom;
            e   = model(tgt, 0, 1, 0, d, RESP_OKAY);
            do_read(tgt, 0, 1, 0, d, RESP_OKAY, o);
            n_checks++;
            if (o.data !== e.data || o.sav_cyc !== e.sav_cyc || o.hs_cyc !== e.hs_cyc || o.proto_err !== 0) begin
                n_fail++;
                $display("[TB] FAIL b2b_%0d: got data=%h sav=%0d hs=%0d err=%0d, required data=%h sav=%0d hs=%0d err=0",
                         n, o.data, o.sav_cyc, o.hs_cyc, o.proto_err, e.data, e.sav_cyc, e.hs_cyc);
            end
        end
    endtask

    task automatic test_reset_mid_data;
        obs_t o, e;
        @(negedge aclk);
        bus.m_axil_arvalid = 1'b1;
        bus.m_axil_rready  = 1'b0;
        bus.s_axil_arready = 2'b01;
        bus.s_axil_rvalid  = '0;
        slv_valid = '0;
        @(negedge aclk);
        slv_valid = 3'b001;
        @(negedge aclk);
        @(negedge aclk);
        bus.m_axil_arvalid  = 1'b0;
        bus.s_axil_arready  = '0;
        bus.s_axil_rvalid   = 2'b01;
        bus.s_axil_rdata[0] = 32'h1234_5678;
        bus.s_axil_rresp[0] = RESP_OKAY;
        #1;
        n_checks++;
        if (bus.m_axil_rvalid !== 1'b1 || bus.m_axil_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_data: got rvalid=%b rdata=%h, required 1/12345678",
                     bus.m_axil_rvalid, bus.m_axil_rdata);
        end
        #2 areset = 1'b1;
        #1;
        n_checks++;
        if ({bus.m_axil_arready, bus.m_axil_rvalid, bus.m_axil_rdata, bus.m_axil_rresp,
             bus.s_axil_arvalid, bus.s_axil_rready} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got rvalid=%b rdata=%h s_rready=%b, required all 0",
                     bus.m_axil_rvalid, bus.m_axil_rdata, bus.s_axil_rready);
        end
        @(negedge aclk);
        areset = 1'b0;
        slv_valid = '0;
        bus.s_axil_rvalid = '0;
        e = model(3'b001, 2, 2, 1, 32'h0BAD_F00D, RESP_OKAY);
        do_read(3'b001, 2, 2, 1, 32'h0BAD_F00D, RESP_OKAY, o);
        n_checks++;
        if (o.data !== e.data || o.hs_cyc !== e.hs_cyc || o.proto_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_read: got data=%h hs=%0d err=%0d, required data=%h hs=%0d err=0",
                     o.data, o.hs_cyc, o.proto_err, e.data, e.hs_cyc);
        end
    endtask

    task automatic test_random;
        obs_t                      o, e;
        logic [NS:0]               tgt;
        int                        ad, rd, rh;
        logic [AXI_DATA_WIDTH-1:0] d;
        logic [1:0]                r;
        for (int n = 0; n < 12; n++) begin
            tgt = (NS+1)'($urandom_range(1, (1 << (NS + 1)) - 1));
            ad  = $urandom_range(0, 4);
            rd  = $urandom_range(0, 3);
            rh  = $urandom_range(0, 3);
            d   = $urandom;
            r   = 2'($urandom);
            e   = model(tgt, ad, rd, rh, d, r);
            do_read(tgt, ad, rd, rh, d, r, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL random_%0d tgt=%b: got sav/ar/rv/hs %0d/%0d/%0d/%0d %h/%b err=%0d, required %0d/%0d/%0d/%0d %h/%b err=0",
                         n, tgt, o.sav_cyc, o.ar_cyc, o.rv_cyc, o.hs_cyc, o.data, o.resp, o.proto_err,
                         e.sav_cyc, e.ar_cyc, e.rv_cyc, e.hs_cyc, e.data, e.resp);
            end
        end
    endtask

`ifdef AXIL_RD_TIMEOUT_EN
    task automatic test_timeout;
        obs_t o, e;
        e = model(3'b001, 0, -1, 0, 32'hDEAD_BEEF, RESP_OKAY);
        do_read(3'b001, 0, -1, 0, 32'hDEAD_BEEF, RESP_OKAY, o);
        n_checks++;
        if (o.resp !== e.resp || o.data !== e.data || o.rv_cyc !== e.rv_cyc || o.proto_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL timeout_slverr: got %h/%b at %0d err=%0d, required %h/%b at %0d err=0",
                     o.data, o.resp, o.rv_cyc, o.proto_err, e.data, e.resp, e.rv_cyc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mapped_read();
        test_unmapped();
        test_rready_hold();
        test_back_to_back();
        test_reset_mid_data();
        test_random();
`ifdef AXIL_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
